serdes_frame_rx: RTL and testbench

Single-clock, FPGA-side receiver for the two-level module-to-FPGA serial link. It replaces the gated-clock deserializer pair (byte-level plus lane-level) with one `sclk`-domain block that uses counters and clock enables. The block recovers framing from a word sync strobe and un-transposes the 64-bit wire frame into `N_LANES` lane words. It delivers each word through a small FIFO with a valid/ready handshake and reports framing errors and overflows.

---
 rtl/serdes_pkg.sv | 25 ++
 rtl/serdes_word_fifo.sv | 48 ++++
 rtl/serdes_frame_rx.sv | 111 +++++++++++
 tb/tb_serdes_frame_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared types and the wire-to-word bit mapping for the serial frame receiver.
// The mapping function is also used by the bench's reference model.
package serdes_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } rx_state_t;

    localparam int N_LANES_DEF    = 8;
    localparam int LANE_WIDTH_DEF = 8;

    // Wire bit n sits in sub-frame n/N_LANES at position n%N_LANES.
    // Both levels are sent MSB first: highest lane first, highest bit first.
    function automatic int wire_to_word_index(input int n,
                                              input int n_lanes    = N_LANES_DEF,
                                              input int lane_width = LANE_WIDTH_DEF);
        int s;
        int p;
        s = n / n_lanes;
        p = n % n_lanes;
        return (n_lanes - 1 - p) * lane_width + (lane_width - 1 - s);
    endfunction

endpackage

// File: rtl/serdes_word_fifo.sv
// Small synchronous word FIFO; a pop frees a slot in the same cycle, so a
// push into a full FIFO is accepted when it coincides with a pop.
module serdes_word_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic [AW:0]                 count;
    logic                        do_push;
    logic                        do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/serdes_frame_rx.sv
// Single-clock serial frame receiver: hunts for word sync, un-transposes the
// wire frame into lane words and hands them out through a small FIFO.
module serdes_frame_rx
    import serdes_pkg::*;
#(
    parameter int N_LANES    = N_LANES_DEF,
    parameter int LANE_WIDTH = LANE_WIDTH_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          sclk,
    input  logic                          reset_n,
    input  logic                          ser_in,
    input  logic                          sync_in,
    output logic [N_LANES*LANE_WIDTH-1:0] out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          locked,
    output logic                          sync_err,
    output logic                          overflow,
    output logic [7:0]                    err_count
);
    localparam int W     = N_LANES * LANE_WIDTH;
    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    rx_state_t      state;
    logic [CNT_W-1:0] bit_cnt;
    logic [W-1:0]   shadow;
    logic [W-1:0]   word_next;
    logic           at_last;
    logic           push;
    logic           pop;
    logic           frame_err;
    logic           fifo_full;
    logic           fifo_empty;

    // Drop the incoming bit straight into its lane slot; the complete word
    // (including bit W-1) is therefore available on the sampling edge.
    always_comb begin
        word_next = shadow;
        for (int n = 0; n < W; n++) begin
            if (bit_cnt == CNT_W'(n))
                word_next[CNT_W'(wire_to_word_index(n, N_LANES, LANE_WIDTH))] = ser_in;
        end
    end

    assign at_last   = (state == LOCKED) && (bit_cnt == LAST);
    assign push      = at_last && sync_in;
    assign frame_err = (state == LOCKED) && (at_last ? !sync_in : sync_in);
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HUNT;
            bit_cnt   <= '0;
            shadow    <= '0;
            locked    <= 1'b0;
            sync_err  <= 1'b0;
            overflow  <= 1'b0;
            err_count <= '0;
        end else begin
            sync_err <= frame_err;
            overflow <= push && fifo_full && !pop;
            if (frame_err && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            case (state)
                HUNT: begin
                    bit_cnt <= '0;
                    if (sync_in) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    shadow <= word_next;
                    if (at_last) begin
                        bit_cnt <= '0;
                        if (!sync_in) begin
                            state  <= HUNT;
                            locked <= 1'b0;
                        end
                    end else if (sync_in) begin
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    serdes_word_fifo #(
        .WIDTH(W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (sclk),
        .rst_n    (reset_n),
        .push     (push),
        .push_data(word_next),
        .pop      (pop),
        .rd_data  (out_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_serdes_frame_rx.sv
// Randomized bench for serdes_frame_rx with a queue-based reference model
// that is checked against the DUT outputs every cycle.
module tb_serdes_frame_rx;
    import serdes_pkg::*;

    localparam int NL    = 8;
    localparam int LW    = 8;
    localparam int W     = NL * LW;
    localparam int DEPTH = 2;

    logic          sclk = 1'b0;
    logic          reset_n;
    logic          ser_in;
    logic          sync_in;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          locked;
    logic          sync_err;
    logic          overflow;
    logic [7:0]    err_count;

    always #5 sclk = ~sclk;

    serdes_frame_rx #(.N_LANES(NL), .LANE_WIDTH(LW), .FIFO_DEPTH(DEPTH)) dut (
        .sclk     (sclk),
        .reset_n  (reset_n),
        .ser_in   (ser_in),
        .sync_in  (sync_in),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .locked   (locked),
        .sync_err (sync_err),
        .overflow (overflow),
        .err_count(err_count)
    );

    // Reference model state: what the outputs must be after the next edge.
    bit           m_locked;
    bit           m_bits[$];
    logic [W-1:0] m_fifo[$];
    bit           m_serr;
    bit           m_ovf;
    int           m_errcnt;

    int n_checks = 0;
    int n_fail   = 0;

    bit           pin_data_pend = 0;
    logic [W-1:0] pin_data;
    bit           pin_err_pend = 0;
    int           pin_err;
    bit           pin_unlock_pend = 0;
    bit           pin_ovf_pend = 0;

    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] decode_bits();
        logic [W-1:0] w;
        w = '0;
        for (int n = 0; n < W; n++) w[wire_to_word_index(n, NL, LW)] = m_bits[n];
        return w;
    endfunction

    task automatic check_outputs();
        cmp("out_valid", out_valid, m_fifo.size() != 0);
        if (m_fifo.size() != 0) cmp("out_data", out_data, m_fifo[0]);
        cmp("locked", locked, m_locked);
        cmp("sync_err", sync_err, m_serr);
        cmp("overflow", overflow, m_ovf);
        cmp("err_count", err_count, m_errcnt);
        if (pin_data_pend) begin
            cmp("pin_valid", out_valid, 1);
            cmp("pin_data", out_data, pin_data);
            pin_data_pend = 0;
        end
        if (pin_err_pend) begin
            cmp("pin_err_count", err_count, pin_err);
            pin_err_pend = 0;
        end
        if (pin_unlock_pend) begin
            cmp("pin_unlocked", locked, 0);
            pin_unlock_pend = 0;
        end
        if (pin_ovf_pend) begin
            cmp("pin_overflow", overflow, 1);
            pin_ovf_pend = 0;
        end
    endtask

    task automatic model_step(input bit rst_n, input bit ser, input bit sync, input bit rdy);
        bit           push;
        bit           pop;
        logic [W-1:0] w;
        if (!rst_n) begin
            m_locked = 0;
            m_bits.delete();
            m_fifo.delete();
            m_serr   = 0;
            m_ovf    = 0;
            m_errcnt = 0;
            return;
        end
        push   = 0;
        w      = '0;
        m_serr = 0;
        pop    = rdy && (m_fifo.size() != 0);
        if (!m_locked) begin
            if (sync) m_locked = 1;
        end else begin
            m_bits.push_back(ser);
            if (m_bits.size() == W) begin
                if (sync) begin
                    w    = decode_bits();
                    push = 1;
                end else begin
                    m_serr   = 1;
                    m_locked = 0;
                end
                m_bits.delete();
            end else if (sync) begin
                m_serr = 1;
                m_bits.delete();
            end
        end
        m_ovf = push && (m_fifo.size() == DEPTH) && !pop;
        if (pop) void'(m_fifo.pop_front());
        if (push && !m_ovf) m_fifo.push_back(w);
        if (m_serr && m_errcnt < 255) m_errcnt++;
    endtask

    task automatic step(input bit rst_n, input bit ser, input bit sync, input bit rdy);
        @(negedge sclk);
        check_outputs();
        reset_n   = rst_n;
        ser_in    = ser;
        sync_in   = sync;
        out_ready = rdy;
        model_step(rst_n, ser, sync, rdy);
    endtask

    task automatic idle(input int cycles, input bit rdy);
        for (int i = 0; i < cycles; i++) step(1, 1'($urandom_range(0, 1)), 0, rdy);
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit sync_last,
                             input bit rdy_body, input bit rdy_last);
        for (int n = 0; n < W; n++)
            step(1, w[wire_to_word_index(n, NL, LW)], (n == W - 1) && sync_last,
                 (n == W - 1) ? rdy_last : rdy_body);
    endtask

    task automatic send_subframes(input logic [NL-1:0] byt);
        for (int n = 0; n < W; n++)
            step(1, byt[NL - 1 - (n % NL)], n == W - 1, 1);
    endtask

    function automatic logic [W-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    initial begin
        reset_n   = 0;
        ser_in    = 0;
        sync_in   = 0;
        out_ready = 0;
        model_step(0, 0, 0, 0);

        // Reset values
        repeat (3) step(0, 0, 0, 0);
        cmp("reset_valid", out_valid, 0);
        cmp("reset_data", out_data, 0);
        cmp("reset_locked", locked, 0);
        cmp("reset_err_count", err_count, 0);

        // Hunt, lock and the fixed 8'h7F pattern
        idle(10, 1);
        step(1, 0, 1, 1);
        for (int k = 0; k < 8; k++) begin
            send_subframes(8'h7F);
            pin_data_pend = 1;
            pin_data      = 64'h00FF_FFFF_FFFF_FFFF;
        end

        // Random transpose traffic with mostly-ready consumer
        for (int k = 0; k < 20; k++)
            send_word(rand_word(), 1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        send_word(rand_word(), 1, 1, 1);

        // Early sync at bit_cnt 30
        idle(30, 1);
        step(1, 1'($urandom_range(0, 1)), 1, 1);
        pin_err_pend = 1;
        pin_err      = 1;
        send_word(rand_word(), 1, 1, 1);

        // Missing sync at bit 63, then re-lock
        send_word(rand_word(), 0, 1, 1);
        pin_unlock_pend = 1;
        pin_err_pend    = 1;
        pin_err         = 2;
        idle(5, 1);
        step(1, 0, 1, 1);
        send_word(rand_word(), 1, 1, 1);

        // Backpressure: two held, third overflows, fourth pushes while popping
        send_word(rand_word(), 1, 1, 0);
        send_word(rand_word(), 1, 0, 0);
        send_word(rand_word(), 1, 0, 0);
        pin_ovf_pend = 1;
        send_word(rand_word(), 1, 0, 1);
        send_word(rand_word(), 1, 1, 1);
        send_word(rand_word(), 1, 1, 0);

        // Reset mid-word with a word still queued
        idle(40, 0);
        step(0, 0, 0, 0);
        #1;
        cmp("rst_now_valid", out_valid, 0);
        cmp("rst_now_data", out_data, 0);
        cmp("rst_now_locked", locked, 0);
        cmp("rst_now_err_count", err_count, 0);
        cmp("rst_now_sync_err", sync_err, 0);
        cmp("rst_now_overflow", overflow, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        idle(70, 1);
        step(1, 1, 1, 1);
        send_word(rand_word(), 1, 1, 1);
        send_word(rand_word(), 1, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
